irq_aggregator: RTL and testbench
=================================

Name: irq_aggregator

Overview:
- Parametrised interrupt aggregator for the processor tile. It collects NUM_SRC peripheral interrupt lines (UART, SPI, motor/QEI and future peripherals) and presents one registered interrupt to the core.
- Per-source features: enable, priority, level/edge mode, claim/complete handshake.
- Programmed over a memory-mapped slave port with the same signal set as the core data bus, behind the WB interconnect.

Parameters:
- NUM_SRC, 8, number of interrupt sources; legal range 1..31; source IDs are 1..NUM_SRC.
- PRIO_BITS, 3, width of each priority field and of the threshold.
- EDGE_MASK, 0, NUM_SRC-bit mask; bit i=1 makes source i+1 rising-edge triggered, 0 makes it level-high.
- SYNC_STAGES, 2, synchroniser flops per source input; minimum 2.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- io_src_irq  in  NUM_SRC  raw peripheral interrupt lines; bit i is source i+1.
- io_dbus_addr  in  8  byte offset; bits [1:0] ignored.
- io_dbus_wdata  in  32  write data.
- io_dbus_rdata  out  32  read data.
- io_dbus_rd_en  in  1  read strobe, one cycle.
- io_dbus_wr_en  in  1  write strobe, one cycle.
- io_dbus_valid  out  1  access-complete pulse.
- io_irq  out  1  interrupt request to the core.

Behaviour:
- Reset (reset low, asynchronous):
  - Clears synchronisers, pending, in-service, enable, threshold and all priorities.
  - Outputs: io_irq=0, io_dbus_valid=0, io_dbus_rdata=0.
  - Releasing reset mid-operation discards every claim in progress.
- Register map (word offsets):
  - 0x00 PENDING: RO, bit i = pending of source i+1.
  - 0x04 ENABLE: RW, NUM_SRC bits.
  - 0x08 CLAIM: read = claim, write = complete.
  - 0x0C THRESHOLD: RW, PRIO_BITS bits.
  - 0x10+4*(id-1) PRIORITY[id]: RW, PRIO_BITS bits.
  - Unmapped reads return 0; unmapped writes are ignored. Unused upper bits read 0.
- Bus handshake:
  - io_dbus_valid pulses exactly one cycle after any rd_en or wr_en, including unmapped addresses.
  - io_dbus_rdata is valid in that same cycle and is held until the next read.
  - If rd_en and wr_en are high together, the write is performed and rdata is unchanged.
  - A new strobe in the cycle valid is high is accepted normally (back-to-back access, 1/cycle).
- Input path: SYNC_STAGES-flop synchroniser per source. Edge detection is done on the synchronised value, so edges have SYNC_STAGES+1 cycles of latency to pending.
- Gateway, level source: pending sets while the synchronised level is 1 and the source is not in-service. After complete, a still-high level re-pends on the next cycle.
- Gateway, edge source: each synchronised rising edge sets pending, independent of in-service. Edges arriving while already pending are merged (depth 1).
- Arbitration (combinational over enabled & pending):
  - Winner = highest priority value; ties go to the lowest ID.
  - Priority 0 never wins.
  - best_id = 0 when there is no candidate.
- io_irq is registered: next = (best_id != 0) and (priority of best_id > THRESHOLD). It falls one cycle after the condition clears.
- Claim (read 0x08):
  - Returns best_id (0 if none), clears that source's pending bit, sets its in-service bit.
  - Claim ignores THRESHOLD; enable and priority>0 still apply.
  - If a new edge on the claimed source arrives in the same cycle, pending stays 1 (set beats clear).
- Complete (write 0x08, wdata[4:0]=id):
  - Clears in-service[id].
  - Ignored if id=0, id>NUM_SRC, or the source is not in-service.
  - In-service sources are excluded from arbitration; an edge source's pending bit remains visible in PENDING.
- Disabling a source (ENABLE bit=0) keeps its pending bit; it becomes eligible again when re-enabled.
- Arithmetic: all compares are unsigned PRIO_BITS-wide. IDs are 5-bit.

Test Plan:
1. Reset: hold reset=0 while io_src_irq toggles -> io_irq=0, PENDING=0; all registers read 0 after release; each access gives io_dbus_valid exactly 1 cycle after its strobe.
2. Single level source:
   - Setup: ENABLE=0x01, PRIORITY[1]=3, THRESHOLD=0, src[0] held 1.
   - Expected: io_irq=1 within SYNC_STAGES+2 cycles; CLAIM read returns 1; io_irq drops next cycle.
   - Then write CLAIM=1 with src[0] still 1 -> pending re-sets and io_irq returns.
3. Priority and tie-break:
   - Setup: sources 2, 3, 5 pending; PRIORITY[2]=4, [3]=6, [5]=6; all enabled.
   - Expected: claims return 3, then 5, then 2, then 0.
4. Threshold: PRIORITY[4]=2, THRESHOLD=2, source 4 pending -> io_irq stays 0 and CLAIM still returns 4; with THRESHOLD=1, io_irq=1.
5. Edge source during service:
   - Setup: EDGE_MASK bit 1 set; pulse src[1], claim returns 2; pulse src[1] again before complete.
   - Expected: PENDING bit1=1 and io_irq=0 while in service; after CLAIM write 2, io_irq=1 and the next claim returns 2.
6. Bad complete and collision:
   - Writing CLAIM=7 while only 2 is in service -> no change.
   - A claim read in the same cycle as a new edge on the claimed source -> PENDING bit stays 1.

Source files
------------

// File: rtl/irq_aggregator.sv
// Purpose : collects NUM_SRC peripheral interrupt lines, gates/prioritises them, presents one registered IRQ.
// Latency : src edge -> pending SYNC_STAGES+1 cycles, pending -> io_irq +1; bus access -> io_dbus_valid 1 cycle.
// Backpr. : none; one bus access per cycle accepted, every strobe answered by a single valid pulse.
// Ports   : clock/reset (async active-low); io_src_irq (bit i = source i+1);
//           io_dbus_* memory-mapped slave (addr/wdata/rd_en/wr_en in, rdata/valid out); io_irq to the core.
module irq_aggregator #(
    parameter int                 NUM_SRC     = 8,
    parameter int                 PRIO_BITS   = 3,
    parameter logic [NUM_SRC-1:0] EDGE_MASK   = '0,
    parameter int                 SYNC_STAGES = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] io_src_irq,
    input  logic [7:0]         io_dbus_addr,
    input  logic [31:0]        io_dbus_wdata,
    output logic [31:0]        io_dbus_rdata,
    input  logic               io_dbus_rd_en,
    input  logic               io_dbus_wr_en,
    output logic               io_dbus_valid,
    output logic               io_irq
);

    logic [NUM_SRC-1:0]   r_sync [SYNC_STAGES];
    logic [NUM_SRC-1:0]   r_sync_d;
    logic [NUM_SRC-1:0]   r_pending;
    logic [NUM_SRC-1:0]   r_in_service;
    logic [NUM_SRC-1:0]   r_enable;
    logic [PRIO_BITS-1:0] r_thr;
    logic [PRIO_BITS-1:0] r_prio [NUM_SRC];
    logic                 r_irq;
    logic                 r_valid;
    logic [31:0]          r_rdata;

    logic [NUM_SRC-1:0]   w_sync;
    logic [5:0]           w_word;
    logic                 w_rd;
    logic                 w_claim_rd;
    logic                 w_compl_wr;
    logic [4:0]           w_compl_id;
    logic [4:0]           w_best_id;
    logic [PRIO_BITS-1:0] w_best_prio;
    logic [NUM_SRC-1:0]   w_claim_vec;
    logic [NUM_SRC-1:0]   w_compl_vec;
    logic [NUM_SRC-1:0]   w_set;
    logic [31:0]          w_rdata;
    logic                 w_unused_bits;

    assign w_sync     = r_sync[SYNC_STAGES-1];
    assign w_word     = io_dbus_addr[7:2];
    // A simultaneous write wins: the read side (rdata update and claim side effect) is suppressed.
    assign w_rd       = io_dbus_rd_en & ~io_dbus_wr_en;
    assign w_claim_rd = w_rd && (w_word == 6'd2);
    assign w_compl_wr = io_dbus_wr_en && (w_word == 6'd2);
    assign w_compl_id = io_dbus_wdata[4:0];
    assign w_unused_bits = &{1'b0, io_dbus_addr[1:0], io_dbus_wdata};

    // Arbitration: strict '>' while scanning upward gives ties to the lowest ID,
    // and starting from priority 0 means a zero-priority source never wins.
    always_comb begin
        w_best_id   = '0;
        w_best_prio = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_enable[i] && r_pending[i] && !r_in_service[i] && (r_prio[i] > w_best_prio)) begin
                w_best_id   = 5'(i + 1);
                w_best_prio = r_prio[i];
            end
        end
    end

    // Gateways. Edge sources set on every rising edge (set beats a same-cycle claim);
    // level sources must not re-pend in the cycle they are being claimed.
    always_comb begin
        w_claim_vec = '0;
        w_compl_vec = '0;
        w_set       = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_claim_vec[i] = w_claim_rd && (w_best_id == 5'(i + 1));
            w_compl_vec[i] = w_compl_wr && (w_compl_id == 5'(i + 1));
            if (EDGE_MASK[i])
                w_set[i] = w_sync[i] & ~r_sync_d[i];
            else
                w_set[i] = w_sync[i] & ~r_in_service[i] & ~w_claim_vec[i];
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_word)
            6'd0:    w_rdata = 32'(r_pending);
            6'd1:    w_rdata = 32'(r_enable);
            6'd2:    w_rdata = 32'(w_best_id);
            6'd3:    w_rdata = 32'(r_thr);
            default: begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (w_word == 6'(4 + i))
                        w_rdata = 32'(r_prio[i]);
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SYNC_STAGES; s++)
                r_sync[s] <= '0;
        end else begin
            r_sync[0] <= io_src_irq;
            for (int s = 1; s < SYNC_STAGES; s++)
                r_sync[s] <= r_sync[s-1];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync_d     <= '0;
            r_pending    <= '0;
            r_in_service <= '0;
            r_enable     <= '0;
            r_thr        <= '0;
            for (int i = 0; i < NUM_SRC; i++)
                r_prio[i] <= '0;
            r_irq        <= 1'b0;
            r_valid      <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_sync_d     <= w_sync;
            r_pending    <= (r_pending & ~w_claim_vec) | w_set;
            // Completing an ID that is not in service clears nothing, so no extra guard is needed.
            r_in_service <= (r_in_service | w_claim_vec) & ~w_compl_vec;
            r_irq        <= (w_best_id != 5'd0) && (w_best_prio > r_thr);
            r_valid      <= io_dbus_rd_en | io_dbus_wr_en;
            if (w_rd)
                r_rdata <= w_rdata;
            if (io_dbus_wr_en) begin
                if (w_word == 6'd1)
                    r_enable <= io_dbus_wdata[NUM_SRC-1:0];
                if (w_word == 6'd3)
                    r_thr <= io_dbus_wdata[PRIO_BITS-1:0];
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (w_word == 6'(4 + i))
                        r_prio[i] <= io_dbus_wdata[PRIO_BITS-1:0];
                end
            end
        end
    end

    assign io_dbus_rdata = r_rdata;
    assign io_dbus_valid = r_valid;
    assign io_irq        = r_irq;

endmodule

// File: tb/tb_irq_aggregator.sv
// Purpose : directed self-checking bench for irq_aggregator (source 2 edge-triggered, others level).
// Latency : stimulus on falling edges, outputs sampled on falling edges.
// Backpr. : n/a.
module tb_irq_aggregator;

    logic        clock;
    logic        reset;
    logic [7:0]  src;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rd_en;
    logic        wr_en;
    logic        valid;
    logic        irq;

    int vectors = 0;
    int errors  = 0;

    localparam logic [7:0] A_PEND  = 8'h00;
    localparam logic [7:0] A_EN    = 8'h04;
    localparam logic [7:0] A_CLAIM = 8'h08;
    localparam logic [7:0] A_THR   = 8'h0C;

    irq_aggregator #(
        .NUM_SRC    (8),
        .PRIO_BITS  (3),
        .EDGE_MASK  (8'h02),
        .SYNC_STAGES(2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .io_src_irq   (src),
        .io_dbus_addr (addr),
        .io_dbus_wdata(wdata),
        .io_dbus_rdata(rdata),
        .io_dbus_rd_en(rd_en),
        .io_dbus_wr_en(wr_en),
        .io_dbus_valid(valid),
        .io_irq       (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) @(negedge clock);
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clock);
        addr = a; wdata = d; wr_en = 1'b1;
        @(negedge clock);
        wr_en = 1'b0;
        chk("wr_valid", 32'(valid), 32'd1);
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
        @(negedge clock);
        addr = a; rd_en = 1'b1;
        @(negedge clock);
        rd_en = 1'b0;
        chk("rd_valid", 32'(valid), 32'd1);
        d = rdata;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_rd(a, d);
        chk(tag, d, exp);
    endtask

    // Bounded wait for io_irq to reach a level; an expired bound shows up as a failed check.
    task automatic wait_irq(input string tag, input logic exp, input int max);
        for (int k = 0; k < max; k++) begin
            @(negedge clock);
            if (irq === exp) break;
        end
        chk(tag, 32'(irq), 32'(exp));
    endtask

    task automatic pulse(input int idx);
        @(negedge clock); src[idx] = 1'b1;
        @(negedge clock); src[idx] = 1'b0;
    endtask

    initial begin
        reset = 1'b0; src = '0; addr = '0; wdata = '0; rd_en = 1'b0; wr_en = 1'b0;

        // 1. Reset with toggling sources, then all registers read zero.
        for (int k = 0; k < 4; k++) begin
            @(negedge clock); src = ~src;
        end
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        src = '0;
        cycles(3);
        reset = 1'b1;
        rd_chk("rst_pending", A_PEND, 32'd0);
        @(negedge clock);
        chk("valid_one_cycle", 32'(valid), 32'd0);
        rd_chk("rst_enable", A_EN, 32'd0);
        rd_chk("rst_claim", A_CLAIM, 32'd0);
        rd_chk("rst_thr", A_THR, 32'd0);
        rd_chk("rst_prio1", 8'h10, 32'd0);
        rd_chk("rst_prio8", 8'h2C, 32'd0);
        bus_wr(8'h30, 32'hFFFF_FFFF);
        rd_chk("unmapped_rd", 8'h30, 32'd0);
        rd_chk("unmapped_hi", 8'hFC, 32'd0);

        // 2. Single level source 1.
        bus_wr(A_EN, 32'h01);
        bus_wr(8'h10, 32'd3);
        bus_wr(A_THR, 32'd0);
        rd_chk("prio1_rb", 8'h10, 32'd3);
        @(negedge clock); src[0] = 1'b1;
        wait_irq("t2_irq_up", 1'b1, 4);
        rd_chk("t2_claim", A_CLAIM, 32'd1);
        chk("t2_irq_hold", 32'(irq), 32'd1);
        @(negedge clock);
        chk("t2_irq_drop", 32'(irq), 32'd0);
        bus_wr(A_CLAIM, 32'd1);
        wait_irq("t2_irq_repend", 1'b1, 3);
        rd_chk("t2_pending", A_PEND, 32'h01);
        src[0] = 1'b0;
        cycles(3);
        rd_chk("t2_claim2", A_CLAIM, 32'd1);
        bus_wr(A_CLAIM, 32'd1);
        cycles(3);
        rd_chk("t2_clean", A_PEND, 32'h00);

        // 3. Priority and tie-break among sources 2 (edge), 3, 5.
        bus_wr(8'h14, 32'd4);
        bus_wr(8'h18, 32'd6);
        bus_wr(8'h20, 32'd6);
        bus_wr(A_EN, 32'h16);
        src[2] = 1'b1; src[4] = 1'b1;
        pulse(1);
        cycles(5);
        rd_chk("t3_pending", A_PEND, 32'h16);
        chk("t3_irq", 32'(irq), 32'd1);
        rd_chk("t3_claim_a", A_CLAIM, 32'd3);
        rd_chk("t3_claim_b", A_CLAIM, 32'd5);
        rd_chk("t3_claim_c", A_CLAIM, 32'd2);
        rd_chk("t3_claim_d", A_CLAIM, 32'd0);
        @(negedge clock);
        chk("t3_irq_off", 32'(irq), 32'd0);
        src[2] = 1'b0; src[4] = 1'b0;
        cycles(3);
        bus_wr(A_CLAIM, 32'd3);
        bus_wr(A_CLAIM, 32'd5);
        bus_wr(A_CLAIM, 32'd2);
        cycles(3);
        rd_chk("t3_clean", A_PEND, 32'h00);

        // 4. Threshold.
        bus_wr(A_EN, 32'h08);
        bus_wr(8'h1C, 32'd2);
        bus_wr(A_THR, 32'd2);
        src[3] = 1'b1;
        cycles(5);
        chk("t4_irq_masked", 32'(irq), 32'd0);
        bus_wr(A_THR, 32'd1);
        wait_irq("t4_irq_thr1", 1'b1, 3);
        bus_wr(A_THR, 32'd2);
        wait_irq("t4_irq_thr2", 1'b0, 3);
        rd_chk("t4_claim", A_CLAIM, 32'd4);
        src[3] = 1'b0;
        cycles(3);
        bus_wr(A_CLAIM, 32'd4);
        bus_wr(A_THR, 32'd0);

        // 5. Edge source re-triggered during service.
        bus_wr(A_EN, 32'h02);
        pulse(1);
        wait_irq("t5_irq_up", 1'b1, 5);
        rd_chk("t5_claim", A_CLAIM, 32'd2);
        pulse(1);
        cycles(4);
        rd_chk("t5_pend_insvc", A_PEND, 32'h02);
        chk("t5_irq_insvc", 32'(irq), 32'd0);

        // 6a. Completing an ID that is not in service changes nothing.
        bus_wr(A_CLAIM, 32'd7);
        cycles(2);
        chk("t6_bad_irq", 32'(irq), 32'd0);
        rd_chk("t6_bad_pend", A_PEND, 32'h02);
        bus_wr(A_CLAIM, 32'd2);
        wait_irq("t5_irq_after_cpl", 1'b1, 3);
        rd_chk("t5_claim2", A_CLAIM, 32'd2);

        // 6b. Claim read lands in the same cycle a new edge sets pending.
        bus_wr(A_CLAIM, 32'd2);
        pulse(1);
        cycles(4);
        @(negedge clock); src[1] = 1'b1;
        @(negedge clock); src[1] = 1'b0;
        @(negedge clock); addr = A_CLAIM; rd_en = 1'b1;
        @(negedge clock); rd_en = 1'b0;
        chk("t6_coll_valid", 32'(valid), 32'd1);
        chk("t6_coll_claim", rdata, 32'd2);
        rd_chk("t6_coll_pend", A_PEND, 32'h02);
        @(negedge clock);
        chk("t6_coll_irq", 32'(irq), 32'd0);

        // Simultaneous read and write: write happens, rdata holds.
        @(negedge clock); addr = A_EN; wdata = 32'h5A; rd_en = 1'b1; wr_en = 1'b1;
        @(negedge clock); rd_en = 1'b0; wr_en = 1'b0;
        chk("rw_valid", 32'(valid), 32'd1);
        chk("rw_rdata_held", rdata, 32'h02);
        rd_chk("rw_enable", A_EN, 32'h5A);

        // Reset mid-service drops pending and in-service state.
        @(negedge clock); reset = 1'b0;
        cycles(2);
        chk("mid_rst_irq", 32'(irq), 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        reset = 1'b1;
        rd_chk("mid_rst_pend", A_PEND, 32'h00);
        bus_wr(A_EN, 32'h02);
        bus_wr(8'h14, 32'd4);
        pulse(1);
        cycles(4);
        rd_chk("mid_rst_claim", A_CLAIM, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
